// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared widths, fetch packet and fetch FSM types for the RISC core
package risc_pkg;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] INSTR_NOP = '0;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } fetch_pkt_t;

   typedef enum logic [1:0] {
      S_RUN,
      S_STALL,
      S_SKID
   } fetch_state_t;

   // PC arithmetic wraps naturally at 2^PC_W
   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
      return pc + PC_W'(1);
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch-to-decode valid/ready handshake carrying {instr, pc}
interface fetch_stage_if;
   import risc_pkg::*;

   logic               out_valid;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;
   logic               dec_ready;

   modport master (output out_valid, output out_instr, output out_pc, input dec_ready);
   modport slave  (input out_valid, input out_instr, input out_pc, output dec_ready);

endinterface

// File: rtl/fetch_stage_skid.sv
// rtl/fetch_stage_skid.sv - fetch_skid_buf: one-entry fetch packet holding register
module fetch_skid_buf
   import risc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       clear,
   input  fetch_pkt_t din,
   output logic       valid,
   output fetch_pkt_t dout
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         dout  <= din;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, imem requests, skid-buffered decode handshake
// Optional FETCH_PERF_CNT_EN adds saturating fetch/bubble performance counters.
module fetch_stage
   import risc_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = '0
)(
   input  logic               clk,
   input  logic               rst,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   fetch_stage_if.master      dec,
   output logic [INSTR_W-1:0] debug_pc_instruction,
   output logic [PC_W-1:0]    debug_pc_out,
   output logic [PC_W-1:0]    debug_pc_input
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_fetch_cnt,
   output logic [31:0]        perf_bubble_cnt
`endif
);

   logic [PC_W-1:0]    pc_q, pc_d, req_pc_q, out_pc_q;
   logic               req_valid_q, out_valid_q;
   logic [INSTR_W-1:0] out_instr_q;
   fetch_state_t       state_q, state_d;
   logic               stall, issue;
   logic               skid_load, skid_clear, skid_valid;
   logic               out_load_inflight, out_load_skid, out_clear;
   fetch_pkt_t         inflight_pkt, skid_pkt;

   always_comb begin
      state_d           = state_q;
      skid_load         = 1'b0;
      skid_clear        = 1'b0;
      out_load_inflight = 1'b0;
      out_load_skid     = 1'b0;
      out_clear         = 1'b0;
      stall             = out_valid_q && !dec.dec_ready;
      issue             = !redirect_valid && !stall;
      inflight_pkt.instr = imem_rdata;
      inflight_pkt.pc    = req_pc_q;

      if (redirect_valid) begin
         skid_clear = 1'b1;
         out_clear  = 1'b1;
         state_d    = S_RUN;
      end else begin
         unique case (state_q)
            S_RUN, S_STALL: begin
               if (stall) begin
                  // Issue is blocked while stalled, so at most one word can be in flight
                  if (req_valid_q) begin
                     skid_load = 1'b1;
                     state_d   = S_SKID;
                  end else begin
                     state_d   = S_STALL;
                  end
               end else begin
                  out_load_inflight = 1'b1;
                  state_d           = S_RUN;
               end
            end
            S_SKID: begin
               if (dec.dec_ready && skid_valid) begin
                  out_load_skid = 1'b1;
                  skid_clear    = 1'b1;
                  state_d       = S_RUN;
               end
            end
            default: state_d = S_RUN;
         endcase
      end

      if (rst)                 pc_d = RESET_PC;
      else if (redirect_valid) pc_d = redirect_pc;
      else if (issue)          pc_d = pc_inc(pc_q);
      else                     pc_d = pc_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RUN;
         pc_q        <= RESET_PC;
         req_valid_q <= 1'b0;
         req_pc_q    <= '0;
         out_valid_q <= 1'b0;
         out_instr_q <= INSTR_NOP;
         out_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_valid_q <= issue;
         if (issue) req_pc_q <= pc_q;

         if (out_clear) begin
            out_valid_q <= 1'b0;
         end else if (out_load_skid) begin
            out_valid_q <= 1'b1;
            out_instr_q <= skid_pkt.instr;
            out_pc_q    <= skid_pkt.pc;
         end else if (out_load_inflight) begin
            out_valid_q <= req_valid_q;
            if (req_valid_q) begin
               out_instr_q <= inflight_pkt.instr;
               out_pc_q    <= inflight_pkt.pc;
            end
         end
      end
   end

   fetch_skid_buf u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .clear (skid_clear),
      .din   (inflight_pkt),
      .valid (skid_valid),
      .dout  (skid_pkt)
   );

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_cnt  <= '0;
         perf_bubble_cnt <= '0;
      end else begin
         if (out_valid_q && dec.dec_ready && perf_fetch_cnt != '1)
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (!out_valid_q && dec.dec_ready && perf_bubble_cnt != '1)
            perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
   end
`endif

   assign imem_addr            = pc_q;
   assign dec.out_valid        = out_valid_q;
   assign dec.out_instr        = out_instr_q;
   assign dec.out_pc           = out_pc_q;
   assign debug_pc_instruction = out_instr_q;
   assign debug_pc_out         = pc_q;
   assign debug_pc_input       = pc_d;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against a stream-level model
module tb_fetch_stage;
   import risc_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               redirect_valid;
   logic [PC_W-1:0]    redirect_pc;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] debug_pc_instruction;
   logic [PC_W-1:0]    debug_pc_out;
   logic [PC_W-1:0]    debug_pc_input;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]        perf_fetch_cnt;
   logic [31:0]        perf_bubble_cnt;
`endif

   fetch_stage_if dec ();

   fetch_stage #(.RESET_PC(8'd0)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .imem_addr            (imem_addr),
      .imem_rdata           (imem_rdata),
      .redirect_valid       (redirect_valid),
      .redirect_pc          (redirect_pc),
      .dec                  (dec.master),
      .debug_pc_instruction (debug_pc_instruction),
      .debug_pc_out         (debug_pc_out),
      .debug_pc_input       (debug_pc_input)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt       (perf_fetch_cnt),
      .perf_bubble_cnt      (perf_bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory: imem[n] = 32'hA5000000 | n
   always_ff @(posedge clk) imem_rdata <= 32'hA500_0000 | 32'(imem_addr);

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [PC_W-1:0] exp_pc, exp_next, held_pc;
   int              since_flush, ready_run;
   bit              held, armed;
   longint          exp_fetch, exp_bubble;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance the model
   task automatic cyc(input bit r, input bit rv, input logic [PC_W-1:0] rpc, input bit rdy);
      logic [PC_W-1:0] exp_d;
      bit              issue, ov;
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      dec.dec_ready  = rdy;
      #1;
      ov    = dec.out_valid;
      issue = !rv && !(ov && !rdy);
      exp_d = r ? 8'd0 : rv ? rpc : issue ? exp_pc + 8'd1 : exp_pc;
      if (armed) begin
         chk("imem_addr", 32'(imem_addr), 32'(exp_pc));
         chk("debug_pc_out", 32'(debug_pc_out), 32'(exp_pc));
         chk("debug_pc_input", 32'(debug_pc_input), 32'(exp_d));
         if (since_flush < 2) chk("bubble_after_flush", 32'(ov), 32'd0);
         if (ready_run >= 2)  chk("no_bubble", 32'(ov), 32'd1);
         if (held) begin
            chk("hold_valid", 32'(ov), 32'd1);
            chk("hold_pc", 32'(dec.out_pc), 32'(held_pc));
         end
         if (ov && rdy) begin
            chk("out_pc", 32'(dec.out_pc), 32'(exp_next));
            chk("out_instr", dec.out_instr, 32'hA500_0000 | 32'(exp_next));
            chk("debug_instr", debug_pc_instruction, 32'hA500_0000 | 32'(exp_next));
         end
      end
      if (r) begin
         exp_pc = 8'd0; exp_next = 8'd0; since_flush = 0; ready_run = 0;
         held = 1'b0; armed = 1'b1; exp_fetch = 0; exp_bubble = 0;
      end else begin
         if (ov && rdy)  exp_fetch++;
         if (!ov && rdy) exp_bubble++;
         if (rv) begin
            exp_pc = rpc; exp_next = rpc; since_flush = 0; ready_run = 0; held = 1'b0;
         end else begin
            if (issue) exp_pc = exp_pc + 8'd1;
            if (ov && rdy) exp_next = exp_next + 8'd1;
            since_flush++;
            ready_run = rdy ? ready_run + 1 : 0;
            held      = ov && !rdy;
            held_pc   = dec.out_pc;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec.dec_ready = 1'b1;
      armed = 1'b0; held = 1'b0; exp_pc = '0; exp_next = '0; held_pc = '0;
      since_flush = 0; ready_run = 0; exp_fetch = 0; exp_bubble = 0;
      @(negedge clk);
      repeat (3)  cyc(1, 0, 8'd0, 1);
      repeat (25) cyc(0, 0, 8'd0, 1);
      repeat (3)  cyc(0, 0, 8'd0, 0);
      repeat (5)  cyc(0, 0, 8'd0, 1);
      cyc(0, 1, 8'd18, 1);
      repeat (6)  cyc(0, 0, 8'd0, 1);
      repeat (2)  cyc(0, 0, 8'd0, 0);
      cyc(0, 1, 8'd33, 0);
      repeat (6)  cyc(0, 0, 8'd0, 1);
      cyc(0, 1, 8'hFE, 1);
      repeat (8)  cyc(0, 0, 8'd0, 1);
      cyc(1, 0, 8'd0, 1);
      repeat (4)  cyc(0, 0, 8'd0, 1);
      for (int i = 0; i < 800; i++)
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
             8'($urandom), $urandom_range(0, 9) < 7);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch_cnt", perf_fetch_cnt, 32'(exp_fetch));
      chk("perf_bubble_cnt", perf_bubble_cnt, 32'(exp_bubble));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
